c_requant: RTL

Output requantization stage that sits directly downstream of the TPU. After the TPU finishes a matmul, this block reads the 128-bit int32 accumulator words from the C global buffer, requantizes each of the four lanes to int8, and writes packed 32-bit results to an output buffer. Per-tensor quantization parameters are latched at start.

---
 rtl/c_requant.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/c_requant.sv
// c_requant: requantizes int32 accumulator words from the C buffer to packed
// int8 results. It reads one 128-bit word per cycle and runs a 3-stage pipeline
// (BRAM read, product, round/shift/offset/clamp).
module c_requant #(
  parameter int unsigned ADDR_BITS  = 12,
  parameter int unsigned SHIFT_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  num_entries,
  input  logic [31:0]           multiplier,
  input  logic [SHIFT_BITS-1:0] shift,
  input  logic [8:0]            output_offset,
  input  logic [7:0]            act_min,
  input  logic [7:0]            act_max,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_BITS-1:0]  C_index,
  input  logic [127:0]          C_data_out,
  output logic                  out_wr_en,
  output logic [ADDR_BITS-1:0]  out_index,
  output logic [31:0]           out_data
);

  localparam int unsigned LANES = 4;
  localparam int unsigned P_W   = 64;             // full signed product
  localparam int unsigned A_W   = P_W + 2;        // headroom for rounding add
  localparam int unsigned S_W   = SHIFT_BITS + 2; // holds 31 + shift

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched per-tensor parameters
  logic [ADDR_BITS-1:0]  r_num;
  logic signed [31:0]    r_mult;
  logic [SHIFT_BITS-1:0] r_shift;
  logic signed [8:0]     r_offset;
  logic signed [7:0]     r_act_min;
  logic signed [7:0]     r_act_max;

  // Address issue and pipeline stages
  logic [ADDR_BITS-1:0]  r_c_index;
  logic                  r_rd_v;
  logic [ADDR_BITS-1:0]  r_rd_idx;
  logic                  r_s1_v;
  logic [ADDR_BITS-1:0]  r_s1_idx;
  logic signed [P_W-1:0] r_prod [LANES];

  // Registered outputs
  logic                  r_busy;
  logic                  r_done;
  logic                  r_out_wr_en;
  logic [ADDR_BITS-1:0]  r_out_index;
  logic [31:0]           r_out_data;

  logic [ADDR_BITS-1:0]  w_last;
  logic signed [31:0]    w_acc  [LANES];
  logic signed [P_W-1:0] w_prod [LANES];
  logic [31:0]           w_res;

  assign w_last = r_num - ADDR_BITS'(1);

  // One lane: round half up at bit (30+shift), arithmetic shift, add offset,
  // clamp to min then max so that max wins when the bounds cross.
  function automatic logic [7:0] requant_lane(
    input logic signed [P_W-1:0]  prod,
    input logic [SHIFT_BITS-1:0]  sh,
    input logic signed [8:0]      off,
    input logic signed [7:0]      lo,
    input logic signed [7:0]      hi
  );
    logic [S_W-1:0]        s;
    logic signed [A_W-1:0] rnd;
    logic signed [A_W-1:0] v;
    logic signed [A_W-1:0] t;
    s   = S_W'(31) + S_W'(sh);
    rnd = A_W'(prod) + (A_W'(1) <<< (s - S_W'(1)));
    v   = (rnd >>> s) + A_W'(off);
    t   = (v < A_W'(lo)) ? A_W'(lo) : v;
    t   = (t > A_W'(hi)) ? A_W'(hi) : t;
    return t[7:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (num_entries == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_c_index == w_last) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Last entry sits in S1 with nothing behind it: S2 takes it now
        if (!r_rd_v && r_s1_v) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Parameter latch on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num     <= '0;
      r_mult    <= '0;
      r_shift   <= '0;
      r_offset  <= '0;
      r_act_min <= '0;
      r_act_max <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_num     <= num_entries;
      r_mult    <= multiplier;
      r_shift   <= shift;
      r_offset  <= output_offset;
      r_act_min <= act_min;
      r_act_max <= act_max;
    end
  end

  // Read address generation, one index per cycle while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_index <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_c_index <= '0;
    end else if (r_state == ST_RUN && r_c_index != w_last) begin
      r_c_index <= r_c_index + ADDR_BITS'(1);
    end
  end

  // Status flags: busy covers every non-idle state, done follows DONE by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= (r_state == ST_DONE);
    end
  end

  // Lane split and signed 32x32 products
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_acc[l]  = C_data_out[(LANES-1-l)*32 +: 32];
      w_prod[l] = P_W'(w_acc[l]) * P_W'(r_mult);
    end
  end

  // Requantize all lanes from the registered products, lane0 in the top byte
  always_comb begin
    w_res = '0;
    for (int l = 0; l < LANES; l++) begin
      w_res[(LANES-1-l)*8 +: 8] = requant_lane(r_prod[l], r_shift, r_offset,
                                               r_act_min, r_act_max);
    end
  end

  // BRAM read stage: track which index the returning data belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v   <= 1'b0;
      r_rd_idx <= '0;
    end else begin
      r_rd_v   <= (r_state == ST_RUN);
      r_rd_idx <= r_c_index;
    end
  end

  // S1: register the four products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v   <= 1'b0;
      r_s1_idx <= '0;
      for (int l = 0; l < LANES; l++) begin
        r_prod[l] <= '0;
      end
    end else begin
      r_s1_v <= r_rd_v;
      if (r_rd_v) begin
        r_s1_idx <= r_rd_idx;
        for (int l = 0; l < LANES; l++) begin
          r_prod[l] <= w_prod[l];
        end
      end
    end
  end

  // S2: register the packed result and the write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_wr_en <= 1'b0;
      r_out_index <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_wr_en <= r_s1_v;
      if (r_s1_v) begin
        r_out_index <= r_s1_idx;
        r_out_data  <= w_res;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign C_index   = r_c_index;
  assign out_wr_en = r_out_wr_en;
  assign out_index = r_out_index;
  assign out_data  = r_out_data;

endmodule
